apb_ro_freq_counter: RTL

- APB3 completer that sits directly downstream of the fabric APB bus converter and consumes its MASTER_* outputs.
- Counts rising edges of an asynchronous, pre-divided ring-oscillator (or GNSS reference) signal over a programmable gate window of PCLK cycles.
- Exposes the result to software through four 32-bit registers.
- One clock domain (PCLK); the measured input passes through a synchroniser.

---
 rtl/apb_ro_freq_counter_if.sv | 21 ++
 rtl/apb_ro_freq_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_ro_freq_counter_if.sv
// APB3 bus bundle between the fabric converter (master) and the frequency counter (slave).
interface apb_ro_freq_counter_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ro_freq_counter.sv
// APB3 completer that counts rising edges of an asynchronous input over a gate window
// of PCLK cycles. Registers: CTRL, GATE, STATUS, COUNT.
module apb_ro_freq_counter #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter logic [31:0] GATE_RESET  = 32'd100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        pclk_i,
  input  logic                        presetn_i,
  apb_ro_freq_counter_if.slave        apb,
  input  logic                        ro_in_i,
  output logic                        done_irq_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic {StIdle, StGate} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   ro_edge;
  logic                   en_q, en_d, cont_q, cont_d, ie_q, ie_d;
  logic [31:0]            gate_q, gate_d, gate_eff;
  logic                   done_q, done_d, ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_next;
  logic                   win_ovf_q, win_ovf_d, win_ovf_next;
  logic [31:0]            timer_q, timer_d;

  logic [1:0]  reg_sel;
  logic        access, addr_err, wr_err, wr_ok;
  logic        wr_ctrl, wr_gate, wr_status;
  logic        start_req, abort_req;
  logic [31:0] count_ext;
  logic        unused_addr;

  assign unused_addr = ^apb.paddr[1:0];
  assign reg_sel     = apb.paddr[3:2];
  assign access      = apb.psel & apb.penable;
  assign addr_err    = |apb.paddr[31:4];
  // STATUS only accepts the DONE clear bit; COUNT is read-only.
  assign wr_err      = apb.pwrite &
                       (((reg_sel == 2'd2) & (|{apb.pwdata[31:2], apb.pwdata[0]})) |
                        (reg_sel == 2'd3));
  assign wr_ok       = access & apb.pwrite & ~addr_err & ~wr_err;
  assign wr_ctrl     = wr_ok & (reg_sel == 2'd0);
  assign wr_gate     = wr_ok & (reg_sel == 2'd1);
  assign wr_status   = wr_ok & (reg_sel == 2'd2);
  assign start_req   = wr_ctrl & apb.pwdata[3] & apb.pwdata[0];
  assign abort_req   = wr_ctrl & ~apb.pwdata[0];

  assign apb.pready   = 1'b1;
  assign apb.pslverr  = access & (addr_err | wr_err);
  assign done_irq_o   = done_q & ie_q;
  assign gate_eff     = (gate_q == 32'd0) ? 32'd1 : gate_q;
  assign count_ext    = 32'(count_q);
  assign ro_edge      = sync_q[SYNC_STAGES-1] & ~delay_q;

  // Read mux: combinational from the address while selected.
  always_comb begin
    apb.prdata = '0;
    if (apb.psel && !addr_err) begin
      unique case (reg_sel)
        2'd0: apb.prdata = {29'd0, ie_q, cont_q, en_q};
        2'd1: apb.prdata = gate_q;
        2'd2: apb.prdata = {29'd0, ovf_q, done_q, state_q == StGate};
        default: apb.prdata = count_ext;
      endcase
    end
  end

  // Saturating edge accumulation for the current gate cycle.
  always_comb begin
    cnt_next     = cnt_q;
    win_ovf_next = win_ovf_q;
    if (ro_edge) begin
      if (cnt_q == CntMax) win_ovf_next = 1'b1;
      else                 cnt_next     = cnt_q + 1'b1;
    end
  end

  // Register writes and gate FSM next state.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    cont_d    = cont_q;
    ie_d      = ie_q;
    gate_d    = gate_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    win_ovf_d = win_ovf_q;
    timer_d   = timer_q;
    // Clear first so a completing window in the same cycle wins.
    done_d    = done_q & ~(wr_status & apb.pwdata[1]);

    if (wr_ctrl) begin
      en_d   = apb.pwdata[0];
      cont_d = apb.pwdata[1];
      ie_d   = apb.pwdata[2];
    end
    if (wr_gate) gate_d = apb.pwdata;

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d   = StGate;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
          timer_d   = gate_eff;
        end
      end
      default: begin
        cnt_d     = cnt_next;
        win_ovf_d = win_ovf_next;
        timer_d   = timer_q - 32'd1;
        if (abort_req) begin
          state_d = StIdle;
        end else if (timer_q == 32'd1) begin
          count_d = cnt_next;
          ovf_d   = win_ovf_next;
          done_d  = 1'b1;
          if (cont_q && en_q) begin
            cnt_d     = '0;
            win_ovf_d = 1'b0;
            timer_d   = gate_eff;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  // Synchroniser and edge-detect delay flop.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_in_i};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Architectural registers and FSM state.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      cont_q    <= 1'b0;
      ie_q      <= 1'b0;
      gate_q    <= GATE_RESET;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      cnt_q     <= '0;
      win_ovf_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      cont_q    <= cont_d;
      ie_q      <= ie_d;
      gate_q    <= gate_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      win_ovf_q <= win_ovf_d;
      timer_q   <= timer_d;
    end
  end

endmodule
